// File: rtl/manch2spi.sv
// Manchester line receiver that re-times each decoded payload bit onto a mode-0 SPI port.
// A preamble bit opens the frame (cs low); a missing mid-bit edge closes it.
module manch2spi #(
    parameter int OSR      = 8,
    parameter int MAX_BITS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          eth_line,
    output logic                          sck,
    output logic                          mosi,
    output logic                          cs,
    output logic [$clog2(MAX_BITS+1)-1:0] bit_count,
    output logic                          frame_done,
    output logic                          err,
    output logic [1:0]                    state_dbg
);
    localparam int BCW = $clog2(MAX_BITS + 1);
    localparam int CW  = $clog2(2 * OSR + 1);

    localparam logic [CW-1:0]  CNT_SAT = CW'(2 * OSR);
    localparam logic [CW-1:0]  MID_LO  = CW'(3 * OSR / 4);
    localparam logic [CW-1:0]  MID_HI  = CW'(5 * OSR / 4);
    localparam logic [CW-1:0]  TMO     = CW'(3 * OSR / 2);
    localparam logic [CW-1:0]  SCK_ON  = CW'(OSR / 4);
    localparam logic [CW-1:0]  SCK_OFF = CW'(3 * OSR / 4 - 1);
    localparam logic [BCW-1:0] BC_MAX  = BCW'(MAX_BITS);

    typedef enum logic [1:0] {
        RECOVER = 2'd0,
        IDLE    = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          line_q;
    logic          ovf;
    logic          fwd;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          line_edge;
    logic          line_rise;

    assign line_edge = sync2 ^ line_q;
    assign line_rise = sync2 & ~line_q;
    assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    assign state_dbg = state;

    // cnt holds the number of cycles since the last accepted edge, so an edge
    // arriving D cycles after the previous one is judged with cnt == D.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            line_q     <= 1'b0;
            state      <= RECOVER;
            cnt        <= '0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            cs         <= 1'b1;
            bit_count  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            fwd        <= 1'b0;
        end else begin
            sync1      <= eth_line;
            sync2      <= sync1;
            line_q     <= sync2;
            frame_done <= 1'b0;
            err        <= 1'b0;
            sck        <= 1'b0;
            cnt        <= cnt_inc;
            case (state)
                RECOVER: begin
                    if (line_edge) begin
                        cnt <= CW'(1);
                    end else if (cnt == CNT_SAT) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (line_rise) begin
                        state     <= ACTIVE;
                        cnt       <= CW'(1);
                        cs        <= 1'b0;
                        bit_count <= '0;
                        ovf       <= 1'b0;
                        fwd       <= 1'b0;
                    end
                end
                ACTIVE: begin
                    sck <= fwd && (cnt >= SCK_ON) && (cnt <= SCK_OFF);
                    if (line_edge) begin
                        if (cnt > MID_HI) begin
                            err   <= 1'b1;
                            cs    <= 1'b1;
                            sck   <= 1'b0;
                            fwd   <= 1'b0;
                            cnt   <= CW'(1);
                            state <= RECOVER;
                        end else if (cnt >= MID_LO) begin
                            cnt <= CW'(1);
                            sck <= 1'b0;
                            if (bit_count < BC_MAX) begin
                                mosi      <= sync2;
                                bit_count <= bit_count + BCW'(1);
                                fwd       <= 1'b1;
                            end else begin
                                fwd <= 1'b0;
                                err <= ~ovf;
                                ovf <= 1'b1;
                            end
                        end
                    end else if (cnt >= TMO) begin
                        cs         <= 1'b1;
                        frame_done <= 1'b1;
                        fwd        <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= RECOVER;
            endcase
        end
    end
endmodule

// File: tb/tb_manch2spi.sv
// Directed bench for manch2spi: a table of whole-frame vectors plus hand-timed
// sequences for reset, sck latency and recovery after a framing error.
module tb_manch2spi;
    localparam int OSR      = 8;
    localparam int MAX_BITS = 64;
    localparam logic [63:0] P = 64'h2f9a77c388e50055;
    localparam logic [1:0] S_RECOVER = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;

    logic       clk = 1'b0;
    logic       rst;
    logic       eth_line;
    logic       sck;
    logic       mosi;
    logic       cs;
    logic [6:0] bit_count;
    logic       frame_done;
    logic       err;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    manch2spi #(.OSR(OSR), .MAX_BITS(MAX_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .eth_line   (eth_line),
        .sck        (sck),
        .mosi       (mosi),
        .cs         (cs),
        .bit_count  (bit_count),
        .frame_done (frame_done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Monitor: counts sck rises, captures mosi LSB-first, counts pulses.
    int          rises, dones, errs, bad_width, sck_cs, cs_lo, hi_len;
    logic [63:0] cap;
    logic        sck_q = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rises = 0; dones = 0; errs = 0; bad_width = 0;
            sck_cs = 0; cs_lo = 0; hi_len = 0; cap = '0;
        end else begin
            if (sck && !sck_q) begin
                rises++;
                cap = {mosi, cap[63:1]};
            end
            if (sck) hi_len++;
            else begin
                if (sck_q && hi_len != OSR / 2) bad_width++;
                hi_len = 0;
            end
            if (frame_done) dones++;
            if (err) errs++;
            if (sck && cs) sck_cs++;
            if (!cs) cs_lo++;
        end
        sck_q = sck;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset(input logic idle);
        eth_line = idle;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3 * OSR) step();
    endtask

    // Preamble, then nbits payload bits LSB first. Interval between mid-bit
    // edges is OSR, or alternately OSR+2 / OSR-2 with jit, or 11 at err_at.
    task automatic drive_frame(input logic idle, input logic [127:0] data, input int nbits,
                               input logic jit, input int err_at, input int tail);
        int d;
        int h;
        eth_line = 1'b0;
        repeat (OSR / 2) step();
        eth_line = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == err_at) d = 11;
            else if (jit) d = (i % 2 == 0) ? OSR + 2 : OSR - 2;
            else d = OSR;
            h = d / 2;
            repeat (h) step();
            eth_line = ~data[i];
            repeat (d - h) step();
            eth_line = data[i];
        end
        repeat (OSR / 2) step();
        eth_line = idle;
        repeat (tail) step();
    endtask

    typedef struct {
        logic         idle;
        logic [127:0] data;
        int           nbits;
        logic         jit;
        int           err_at;
        int           exp_rises;
        logic [63:0]  exp_cap;
        int           exp_bc;
        int           exp_done;
        int           exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] got_cap;

        vecs[0] = '{1'b1, {64'd0, P}, 64, 1'b0, -1, 64, P, 64, 1, 0};
        vecs[1] = '{1'b0, {64'd0, P}, 64, 1'b0, -1, 64, P, 64, 1, 0};
        vecs[2] = '{1'b1, {64'd0, P}, 64, 1'b1, -1, 64, P, 64, 1, 0};
        vecs[3] = '{1'b0, {58'd0, 6'b101101, P}, 70, 1'b0, -1, 64, P, 64, 1, 1};
        vecs[4] = '{1'b1, {120'd0, 8'ha5}, 8, 1'b0, -1, 8, 64'h00000000000000a5, 8, 1, 0};
        vecs[5] = '{1'b0, {64'd0, P}, 12, 1'b0, 5, 5, 64'h0000000000000015, 5, 0, 1};
        vecs[6] = '{1'b1, {127'd0, 1'b0}, 1, 1'b1, -1, 1, 64'h0, 1, 1, 0};

        // Reset with the line held high, then the 0->1 synchronizer edge.
        rst = 1'b1;
        eth_line = 1'b1;
        step();
        step();
        check("rst_sck", {63'd0, sck}, 64'd0);
        check("rst_mosi", {63'd0, mosi}, 64'd0);
        check("rst_cs", {63'd0, cs}, 64'd1);
        check("rst_bit_count", {57'd0, bit_count}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_state", {62'd0, state_dbg}, {62'd0, S_RECOVER});
        rst = 1'b0;
        repeat (18) step();
        check("recover_before_16_stable", {62'd0, state_dbg}, {62'd0, S_RECOVER});
        step();
        check("idle_after_16_stable", {62'd0, state_dbg}, {62'd0, S_IDLE});
        repeat (10) step();
        check("no_cs_fall_after_rst", 64'(cs_lo), 64'd0);
        check("no_sck_after_rst", 64'(rises), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset(vecs[i].idle);
            drive_frame(vecs[i].idle, vecs[i].data, vecs[i].nbits, vecs[i].jit,
                        vecs[i].err_at, 3 * OSR);
            got_cap = (rises == 0) ? 64'd0 : (cap >> (64 - rises));
            check($sformatf("v%0d_sck_rises", i), 64'(rises), 64'(vecs[i].exp_rises));
            check($sformatf("v%0d_capture", i), got_cap, vecs[i].exp_cap);
            check($sformatf("v%0d_bit_count", i), {57'd0, bit_count}, 64'(vecs[i].exp_bc));
            check($sformatf("v%0d_frame_done", i), 64'(dones), 64'(vecs[i].exp_done));
            check($sformatf("v%0d_err", i), 64'(errs), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_sck_width", i), 64'(bad_width), 64'd0);
            check($sformatf("v%0d_sck_with_cs_high", i), 64'(sck_cs), 64'd0);
            check($sformatf("v%0d_end_state", i), {62'd0, state_dbg}, {62'd0, S_IDLE});
        end

        // Cycle-exact latency of cs, mosi and sck, then reset while sck is high.
        do_reset(1'b0);
        eth_line = 1'b1;
        step();
        step();
        check("lat_cs_still_high", {63'd0, cs}, 64'd1);
        step();
        check("lat_cs_low", {63'd0, cs}, 64'd0);
        check("lat_bc_cleared", {57'd0, bit_count}, 64'd0);
        step();
        eth_line = 1'b0;
        repeat (4) step();
        eth_line = 1'b1;
        step();
        step();
        check("lat_bc_before", {57'd0, bit_count}, 64'd0);
        step();
        check("lat_mosi", {63'd0, mosi}, 64'd1);
        check("lat_bc_after", {57'd0, bit_count}, 64'd1);
        step();
        check("lat_sck_low", {63'd0, sck}, 64'd0);
        step();
        check("lat_sck_high", {63'd0, sck}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sck", {63'd0, sck}, 64'd0);
        check("midrst_cs", {63'd0, cs}, 64'd1);
        check("midrst_bc", {57'd0, bit_count}, 64'd0);
        check("midrst_state", {62'd0, state_dbg}, {62'd0, S_RECOVER});
        repeat (3) begin
            eth_line = 1'b0;
            repeat (4) step();
            eth_line = 1'b1;
            repeat (4) step();
        end
        eth_line = 1'b0;
        repeat (30) step();
        check("midrst_no_sck", 64'(rises), 64'd0);
        check("midrst_no_done", 64'(dones), 64'd0);
        check("midrst_no_err", 64'(errs), 64'd0);

        // Framing error, an immediate frame that must be ignored, then a good one.
        do_reset(1'b1);
        drive_frame(1'b1, {64'd0, P}, 3, 1'b0, 2, 6);
        check("ferr_err", 64'(errs), 64'd1);
        check("ferr_rises", 64'(rises), 64'd2);
        check("ferr_bc", {57'd0, bit_count}, 64'd2);
        check("ferr_recover", {62'd0, state_dbg}, {62'd0, S_RECOVER});
        drive_frame(1'b1, {120'd0, 8'ha5}, 8, 1'b0, -1, 3 * OSR);
        check("early_ignored", 64'(rises), 64'd2);
        check("early_no_done", 64'(dones), 64'd0);
        check("early_then_idle", {62'd0, state_dbg}, {62'd0, S_IDLE});
        drive_frame(1'b1, {120'd0, 8'ha5}, 8, 1'b0, -1, 3 * OSR);
        check("late_rises", 64'(rises), 64'd10);
        check("late_capture", {56'd0, cap[63:56]}, 64'h00000000000000a5);
        check("late_bc", {57'd0, bit_count}, 64'd8);
        check("late_done", 64'(dones), 64'd1);
        check("late_err", 64'(errs), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
